// File: rtl/aes_128_key_sched_ctrl.sv
// AES-128 key schedule load controller: accepts a cipher key, drives the expansion
// engine, streams 22 64-bit round-key words to the shadow bank and switches banks.
module aes_128_key_sched_ctrl #(
  parameter int KEY_SET = 22,
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 2
) (
  input  logic         clk,
  input  logic         kill_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_load_ack,
  output logic         exp_start,
  output logic [127:0] exp_key,
  input  logic         exp_rk_valid,
  input  logic [127:0] exp_rk,
  output logic         exp_rk_ready,
  output logic         en_wr,
  output logic [63:0]  key_round_wr,
  input  logic         blk_idle,
  output logic         switch_key,
  output logic         active_bank,
  output logic         busy,
  output logic         key_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [4:0]    LAST_WORD   = 5'(KEY_SET - 1);
  localparam logic [TW-1:0] TMO         = TW'(TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_EXPAND,
    S_WAIT_SW,
    S_SETTLE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_phase;
  logic [127:0]  r_rk;
  logic [127:0]  r_key;
  logic [4:0]    r_wcnt;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;
  logic          r_bank;
  logic          w_accept;

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // r_phase: 0 = no half-write pending, 1 = upper half due, 2 = lower half due
  always_comb begin
    w_next       = r_state;
    key_load_ack = 1'b0;
    exp_start    = 1'b0;
    exp_rk_ready = 1'b0;
    en_wr        = 1'b0;
    key_err      = 1'b0;
    switch_key   = 1'b0;
    busy         = 1'b1;
    w_accept     = 1'b0;
    key_round_wr = 64'd0;
    case (r_state)
      S_IDLE: begin
        key_load_ack = 1'b1;
        busy         = 1'b0;
        if (key_load) w_next = S_START;
      end
      S_START: begin
        exp_start = 1'b1;
        w_next    = S_EXPAND;
      end
      S_EXPAND: begin
        en_wr        = (r_phase != 2'd0);
        exp_rk_ready = (r_phase == 2'd0);
        w_accept     = exp_rk_valid && exp_rk_ready;
        if (r_phase == 2'd1)      key_round_wr = r_rk[127:64];
        else if (r_phase == 2'd2) key_round_wr = r_rk[63:0];
        if (en_wr && (r_wcnt == LAST_WORD)) begin
          w_next = S_WAIT_SW;
        end else if (!w_accept && (r_phase == 2'd0) && (r_timer >= TMO)) begin
          key_err = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_WAIT_SW: begin
        if (blk_idle) begin
          switch_key = 1'b1;
          w_next     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Timer holds the number of cycles since exp_start or the last accepted beat
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_phase  <= 2'd0;
      r_rk     <= '0;
      r_key    <= '0;
      r_wcnt   <= 5'd0;
      r_timer  <= '0;
      r_settle <= '0;
      r_bank   <= 1'b0;
    end else begin
      if (switch_key) r_bank <= ~r_bank;
      if (key_load && key_load_ack) r_key <= key_in;
      case (r_state)
        S_START: begin
          r_phase <= 2'd0;
          r_wcnt  <= 5'd0;
          r_timer <= TW'(1);
        end
        S_EXPAND: begin
          if (w_accept) begin
            r_rk    <= exp_rk;
            r_phase <= 2'd1;
            r_timer <= TW'(1);
          end else begin
            if (r_phase == 2'd1)      r_phase <= 2'd2;
            else if (r_phase == 2'd2) r_phase <= 2'd0;
            if (r_timer != TMO) r_timer <= r_timer + 1'b1;
          end
          if (en_wr && (r_wcnt != LAST_WORD)) r_wcnt <= r_wcnt + 5'd1;
        end
        S_WAIT_SW: r_settle <= '0;
        S_SETTLE:  r_settle <= r_settle + 1'b1;
        default: ;
      endcase
    end
  end

  assign exp_key     = r_key;
  assign active_bank = r_bank;

endmodule
